// File: rtl/cnt_monitor.sv
// cnt_monitor: watches an 8-bit upstream counter and reports discontinuities.
//
// An IDLE/SYNC/TRACK FSM follows cnt_in. Once tracking, every sample is
// classified against the previous one: hold, +1 and 0xFF->0x00 are legal
// (the latter logged as WRAP); a drop to 0x00 is a RESTART; anything else
// is a JUMP. Events are queued in a small FIFO with a valid/ready head.
//
// Ports:
//   clk        rising-edge clock
//   res_n      asynchronous active-low reset
//   cnt_in     upstream counter value, sampled every edge
//   cnt_en     monitoring enable; low forces IDLE
//   clr        synchronous clear of err_flag, ovf, wrap_cnt
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer accepts the head
//   evt_type   head event type (0 WRAP, 1 JUMP, 2 RESTART)
//   evt_value  cnt_in value that raised the head event
//   wrap_cnt   saturating WRAP counter
//   err_flag   sticky JUMP/RESTART seen
//   ovf        sticky event dropped on a full FIFO
module cnt_monitor #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WRAP_W     = 16
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic [7:0]        cnt_in,
  input  logic              cnt_en,
  input  logic              clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_type,
  output logic [7:0]        evt_value,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err_flag,
  output logic              ovf
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSync, StTrack} state_e;
  typedef enum logic [1:0] {EvtWrap = 2'd0, EvtJump = 2'd1, EvtRestart = 2'd2} evt_e;

  state_e state_q;
  logic [7:0] prev_q;

  // Event classification
  logic evt_push;
  evt_e evt_kind;
  logic step_ok;

  always_comb begin
    evt_push = 1'b0;
    evt_kind = EvtJump;
    step_ok  = (prev_q != 8'hFF) && (cnt_in == prev_q + 8'd1);
    if (state_q == StTrack && cnt_en && cnt_in != prev_q && !step_ok) begin
      evt_push = 1'b1;
      if (prev_q == 8'hFF && cnt_in == 8'h00) begin
        evt_kind = EvtWrap;
      end else if (cnt_in == 8'h00) begin
        // prev can be neither 0x00 (hold) nor 0xFF (wrap) here
        evt_kind = EvtRestart;
      end else begin
        evt_kind = EvtJump;
      end
    end
  end

  // FSM and previous-sample register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= StIdle;
      prev_q  <= 8'h00;
    end else if (!cnt_en) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: state_q <= StSync;
        StSync: begin
          prev_q  <= cnt_in;
          state_q <= StTrack;
        end
        StTrack: prev_q <= cnt_in;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Event FIFO
  logic [1:0]      type_mem  [FIFO_DEPTH];
  logic [7:0]      value_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            empty, full, pop, push_ok, drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign pop     = !empty && evt_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign push_ok = evt_push && (!full || pop);
  assign drop    = evt_push && full && !pop;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push_ok) begin
      type_mem[wr_ptr_q]  <= evt_kind;
      value_mem[wr_ptr_q] <= cnt_in;
    end
  end

  assign evt_valid = !empty;
  assign evt_type  = empty ? 2'd0 : type_mem[rd_ptr_q];
  assign evt_value = empty ? 8'h00 : value_mem[rd_ptr_q];

  // Status flags; clr overrides same-edge updates
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wrap_cnt <= '0;
      err_flag <= 1'b0;
      ovf      <= 1'b0;
    end else if (clr) begin
      wrap_cnt <= '0;
      err_flag <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (evt_push && evt_kind == EvtWrap && wrap_cnt != {WRAP_W{1'b1}}) begin
        wrap_cnt <= wrap_cnt + 1'b1;
      end
      if (evt_push && evt_kind != EvtWrap) err_flag <= 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cnt_monitor.sv
module tb_cnt_monitor;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] cnt_in;
  logic       cnt_en;
  logic       clr;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_type;
  logic [7:0] evt_value;
  logic [3:0] wrap_cnt;
  logic       err_flag;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  cnt_monitor #(.FIFO_DEPTH(4), .WRAP_W(4)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .cnt_in    (cnt_in),
    .cnt_en    (cnt_en),
    .clr       (clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_type  (evt_type),
    .evt_value (evt_value),
    .wrap_cnt  (wrap_cnt),
    .err_flag  (err_flag),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (evt_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %0b want 0", evt_valid); end
    checks++; if (evt_type !== 2'd0) begin errors++;
      $display("FAIL rst_type: got %0d want 0", evt_type); end
    checks++; if (evt_value !== 8'h00) begin errors++;
      $display("FAIL rst_value: got %0h want 00", evt_value); end
    checks++; if (wrap_cnt !== 4'h0) begin errors++;
      $display("FAIL rst_wrap_cnt: got %0h want 0", wrap_cnt); end
    checks++; if (err_flag !== 1'b0) begin errors++;
      $display("FAIL rst_err: got %0b want 0", err_flag); end
    checks++; if (ovf !== 1'b0) begin errors++;
      $display("FAIL rst_ovf: got %0b want 0", ovf); end
    res_n = 1'b1;
  endtask

  task automatic test_wrap();
    evt_ready = 1'b1;
    cnt_en    = 1'b1;
    cnt_in    = 8'hFD;
    tick();  // IDLE -> SYNC
    tick();  // SYNC loads FD
    cnt_in = 8'hFE; tick();
    cnt_in = 8'hFF; tick();
    checks++; if (evt_valid !== 1'b0) begin errors++;
      $display("FAIL wrap_no_evt: got %0b want 0", evt_valid); end
    cnt_in = 8'h00; tick();
    checks++; if (evt_valid !== 1'b1) begin errors++;
      $display("FAIL wrap_valid: got %0b want 1", evt_valid); end
    checks++; if (evt_type !== 2'd0) begin errors++;
      $display("FAIL wrap_type: got %0d want 0", evt_type); end
    checks++; if (evt_value !== 8'h00) begin errors++;
      $display("FAIL wrap_value: got %0h want 00", evt_value); end
    checks++; if (wrap_cnt !== 4'h1) begin errors++;
      $display("FAIL wrap_cnt1: got %0h want 1", wrap_cnt); end
    cnt_in = 8'h01; tick();
    checks++; if (evt_valid !== 1'b0) begin errors++;
      $display("FAIL wrap_single: got %0b want 0", evt_valid); end
    checks++; if (err_flag !== 1'b0) begin errors++;
      $display("FAIL wrap_err: got %0b want 0", err_flag); end
  endtask

  task automatic test_jump_restart();
    cnt_en = 1'b0;
    cnt_in = 8'h10;  // would be a jump from 01 if still enabled
    tick();
    checks++; if (evt_valid !== 1'b0) begin errors++;
      $display("FAIL dis_no_evt: got %0b want 0", evt_valid); end
    cnt_en = 1'b1;
    tick();  // IDLE -> SYNC
    tick();  // SYNC loads 10
    cnt_in = 8'h11; tick();
    checks++; if (evt_valid !== 1'b0) begin errors++;
      $display("FAIL jr_normal: got %0b want 0", evt_valid); end
    cnt_in = 8'h15; tick();
    checks++; if (evt_valid !== 1'b1) begin errors++;
      $display("FAIL jump_valid: got %0b want 1", evt_valid); end
    checks++; if (evt_type !== 2'd1) begin errors++;
      $display("FAIL jump_type: got %0d want 1", evt_type); end
    checks++; if (evt_value !== 8'h15) begin errors++;
      $display("FAIL jump_value: got %0h want 15", evt_value); end
    checks++; if (err_flag !== 1'b1) begin errors++;
      $display("FAIL jump_err: got %0b want 1", err_flag); end
    cnt_in = 8'h16; tick();
    checks++; if (evt_valid !== 1'b0) begin errors++;
      $display("FAIL jump_popped: got %0b want 0", evt_valid); end
    cnt_in = 8'h00; tick();
    checks++; if (evt_type !== 2'd2 || evt_valid !== 1'b1) begin errors++;
      $display("FAIL restart_type: got %0d/%0b want 2/1", evt_type, evt_valid); end
    checks++; if (evt_value !== 8'h00) begin errors++;
      $display("FAIL restart_value: got %0h want 00", evt_value); end
    clr = 1'b1; tick(); clr = 1'b0;  // cnt_in holds at 00
    checks++; if (err_flag !== 1'b0 || wrap_cnt !== 4'h0) begin errors++;
      $display("FAIL clr: got err=%0b wrap=%0h want 0/0", err_flag, wrap_cnt); end
  endtask

  task automatic test_overflow();
    logic [7:0] jumps [5] = '{8'h40, 8'h80, 8'h20, 8'h60, 8'h90};
    logic [7:0] order [4] = '{8'h80, 8'h20, 8'h60, 8'h30};
    evt_ready = 1'b0;
    cnt_en = 1'b0; tick();
    cnt_en = 1'b1; cnt_in = 8'h00;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      cnt_in = jumps[i];
      tick();
      if (i == 3) begin
        checks++; if (ovf !== 1'b0) begin errors++;
          $display("FAIL ovf_early: got %0b want 0", ovf); end
      end
    end
    checks++; if (ovf !== 1'b1) begin errors++;
      $display("FAIL ovf_set: got %0b want 1", ovf); end
    checks++; if (evt_value !== 8'h40 || evt_type !== 2'd1) begin errors++;
      $display("FAIL ovf_head: got %0h/%0d want 40/1", evt_value, evt_type); end
    evt_ready = 1'b1;
    cnt_in = 8'h30; tick();  // sixth event with FIFO full and a pop
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_value !== order[i]) begin errors++;
        $display("FAIL fifo_order%0d: got %0b/%0h want 1/%0h", i, evt_valid, evt_value,
                 order[i]); end
      tick();
    end
    checks++; if (evt_valid !== 1'b0) begin errors++;
      $display("FAIL fifo_drained: got %0b want 0", evt_valid); end
    checks++; if (ovf !== 1'b1) begin errors++;
      $display("FAIL ovf_sticky: got %0b want 1", ovf); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++;
      $display("FAIL ovf_clr: got %0b want 0", ovf); end
  endtask

  task automatic test_wrap_sat();
    for (int i = 0; i < 15; i++) begin
      cnt_in = 8'hFF; tick();
      cnt_in = 8'h00; tick();
    end
    checks++; if (wrap_cnt !== 4'hF) begin errors++;
      $display("FAIL wrap_cnt15: got %0h want f", wrap_cnt); end
    cnt_in = 8'hFF; tick();
    cnt_in = 8'h00; tick();
    checks++; if (wrap_cnt !== 4'hF) begin errors++;
      $display("FAIL wrap_sat: got %0h want f", wrap_cnt); end
    cnt_in = 8'hFF; tick();
    cnt_in = 8'h00; clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (wrap_cnt !== 4'h0 || err_flag !== 1'b0) begin errors++;
      $display("FAIL clr_wins: got wrap=%0h err=%0b want 0/0", wrap_cnt, err_flag); end
    checks++; if (evt_valid !== 1'b1 || evt_type !== 2'd0 || evt_value !== 8'h00) begin
      errors++;
      $display("FAIL clr_evt_kept: got %0b/%0d/%0h want 1/0/00", evt_valid, evt_type,
               evt_value); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq [5] = '{8'hFF, 8'h00, 8'h40, 8'h80, 8'h20};
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cnt_in = seq[i];
      tick();
    end
    checks++; if (evt_valid !== 1'b1 || wrap_cnt !== 4'h1) begin errors++;
      $display("FAIL pre_rst: got %0b/%0h want 1/1", evt_valid, wrap_cnt); end
    checks++; if (err_flag !== 1'b1 || ovf !== 1'b1) begin errors++;
      $display("FAIL pre_rst_flags: got %0b/%0b want 1/1", err_flag, ovf); end
    #3 res_n = 1'b0;
    #1;
    checks++; if (evt_valid !== 1'b0 || wrap_cnt !== 4'h0) begin errors++;
      $display("FAIL async_rst: got %0b/%0h want 0/0", evt_valid, wrap_cnt); end
    checks++; if (err_flag !== 1'b0 || ovf !== 1'b0) begin errors++;
      $display("FAIL async_rst_flags: got %0b/%0b want 0/0", err_flag, ovf); end
    #1 res_n = 1'b1;
    evt_ready = 1'b1;
    cnt_in = 8'hFF; tick();  // IDLE -> SYNC
    cnt_in = 8'hFF; tick();  // SYNC loads FF
    checks++; if (evt_valid !== 1'b0) begin errors++;
      $display("FAIL post_rst_sync: got %0b want 0", evt_valid); end
    cnt_in = 8'h00; tick();
    checks++; if (evt_valid !== 1'b1 || evt_type !== 2'd0 || wrap_cnt !== 4'h1) begin
      errors++;
      $display("FAIL post_rst_wrap: got %0b/%0d/%0h want 1/0/1", evt_valid, evt_type,
               wrap_cnt); end
  endtask

  task automatic test_disable();
    cnt_en = 1'b0; tick();
    cnt_en = 1'b1; cnt_in = 8'h20;
    tick();
    tick();
    tick();  // TRACK holding 20
    checks++; if (evt_valid !== 1'b0) begin errors++;
      $display("FAIL dis_track: got %0b want 0", evt_valid); end
    cnt_en = 1'b0; cnt_in = 8'h80; tick();
    checks++; if (evt_valid !== 1'b0 || err_flag !== 1'b0) begin errors++;
      $display("FAIL dis_jump: got %0b/%0b want 0/0", evt_valid, err_flag); end
    tick();
    checks++; if (evt_valid !== 1'b0) begin errors++;
      $display("FAIL dis_idle: got %0b want 0", evt_valid); end
    cnt_en = 1'b1; tick();  // IDLE -> SYNC
    cnt_in = 8'h90; tick(); // SYNC loads 90
    checks++; if (evt_valid !== 1'b0 || err_flag !== 1'b0) begin errors++;
      $display("FAIL reen_sync: got %0b/%0b want 0/0", evt_valid, err_flag); end
    cnt_in = 8'h91; tick();
    checks++; if (evt_valid !== 1'b0 || err_flag !== 1'b0) begin errors++;
      $display("FAIL reen_prev: got %0b/%0b want 0/0", evt_valid, err_flag); end
  endtask

  initial begin
    res_n     = 1'b0;
    cnt_in    = 8'h00;
    cnt_en    = 1'b0;
    clr       = 1'b0;
    evt_ready = 1'b0;
    test_reset();
    test_wrap();
    test_jump_restart();
    test_overflow();
    test_wrap_sat();
    test_reset_mid();
    test_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnt_monitor.md
CNT_MONITOR -- requirements
Module: cnt_monitor

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the event FIFO depth (power of two, 2..16).
REQ-002 Parameter WRAP_W, default 16, SHALL set the width of wrap_cnt.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 res_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cnt_in  input  8  SHALL carry the upstream counter value (cnt_out of counter), sampled every clk edge.
REQ-006 cnt_en  input  1  SHALL enable monitoring when high.
REQ-007 clr  input  1  SHALL synchronously clear err_flag, ovf and wrap_cnt.
REQ-008 evt_valid  output  1  SHALL indicate the FIFO head holds an event.
REQ-009 evt_ready  input  1  SHALL be the consumer's acceptance of the FIFO head.
REQ-010 evt_type  output  2  SHALL give the head event type: 0 WRAP, 1 JUMP, 2 RESTART; 3 unused.
REQ-011 evt_value  output  8  SHALL give the cnt_in value that caused the head event.
REQ-012 wrap_cnt  output  WRAP_W  SHALL count WRAP events.
REQ-013 err_flag  output  1  SHALL be the sticky JUMP/RESTART indicator.
REQ-014 ovf  output  1  SHALL be the sticky FIFO-overflow (event dropped) indicator.

Function
REQ-015 FSM states SHALL be IDLE, SYNC and TRACK.
REQ-016 IDLE: cnt_en high SHALL move to SYNC; no checking, no events.
REQ-017 SYNC: SHALL load prev <= cnt_in and move to TRACK; no event in this cycle.
REQ-018 In any state, cnt_en low SHALL force IDLE on the next edge, with no event for that cycle.
REQ-019 TRACK, each edge: cnt_in == prev SHALL be a hold (no event).
REQ-020 TRACK: cnt_in == prev+1 with prev != 0xFF SHALL be normal (no event).
REQ-021 TRACK: prev == 0xFF and cnt_in == 0x00 SHALL enqueue WRAP and increment wrap_cnt, saturating at all-ones.
REQ-022 TRACK: cnt_in == 0x00 with prev not in {0x00, 0xFF} SHALL enqueue RESTART and set err_flag.
REQ-023 TRACK: any other value SHALL enqueue JUMP and set err_flag.
REQ-024 TRACK: prev SHALL load cnt_in on every edge.
REQ-025 An event SHALL be written at the same edge that samples its cnt_in; evt_valid SHALL be high in the following cycle if the FIFO was empty (latency 1).
REQ-026 evt_valid SHALL equal FIFO not-empty; evt_type/evt_value SHALL be stable while evt_valid high and evt_ready low.
REQ-027 A pop SHALL occur on an edge where evt_valid and evt_ready are both high.
REQ-028 A push while full with no same-edge pop SHALL drop the new event and set ovf; FIFO contents are unchanged.
REQ-029 A push while full with a same-edge pop SHALL be accepted; occupancy is unchanged.
REQ-030 A push and pop on the same edge with FIFO empty SHALL NOT occur, because evt_valid is low.
REQ-031 clr high SHALL clear err_flag, ovf and wrap_cnt; it SHALL win over a same-edge set or increment.
REQ-032 A same-edge event SHALL still be enqueued when clr is high.
REQ-033 clr SHALL NOT affect the FSM or FIFO.

Reset
REQ-034 res_n low SHALL, asynchronously: set FSM to IDLE; set prev=0x00; empty the FIFO; set evt_valid=0, evt_type=0, evt_value=0x00, wrap_cnt=0, err_flag=0, ovf=0.
REQ-035 Reset asserted mid-operation SHALL discard all queued events.
REQ-036 After res_n rises, the first edge SHALL behave as an edge from IDLE.

Verification
REQ-037 cnt_en=1, cnt_in incrementing from 0xFD through 0x01, evt_ready=1 -> exactly one WRAP with evt_value=0x00; wrap_cnt=1; err_flag=0.
REQ-038 In TRACK, cnt_in 0x10,0x11,0x15 -> JUMP with evt_value=0x15; err_flag=1. Then cnt_in 0x16,0x00 -> RESTART with evt_value=0x00.
REQ-039 evt_ready=0, FIFO_DEPTH=4, five JUMP events -> four held in order and ovf=1. Raise evt_ready while a sixth event arrives with FIFO full -> sixth accepted, occupancy stays 4.
REQ-040 wrap_cnt at all-ones (WRAP_W=4: 0xF) plus another WRAP -> wrap_cnt stays 0xF. clr on the same edge as a WRAP -> wrap_cnt=0 and the event is still queued.
REQ-041 Three events queued, then res_n pulsed low mid-cycle -> evt_valid=0 immediately, wrap_cnt=0, err_flag=0, ovf=0. After release, a WRAP is detected only after the SYNC cycle.
REQ-042 cnt_en dropped during TRACK, then a jump 0x20->0x80 applied while cnt_en=0 -> no event. Re-enable -> SYNC loads prev with no event.
